tlc_phase_fsm: RTL and testbench



---
 rtl/tlc_pkg.sv | 31 +++
 rtl/tlc_phase_timer.sv | 28 ++
 rtl/tlc_phase_fsm.sv | 158 +++++++++++++++
 tb/tb_tlc_phase_fsm.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/tlc_pkg.sv
// Shared types and constants for the traffic-light phase controller.
// Optional night flashing mode is enabled by defining TLC_NIGHT_FLASH_EN.
package tlc_pkg;

  typedef enum logic [2:0] {
    NS_GREEN  = 3'd0,
    NS_YELLOW = 3'd1,
    ALL_RED_1 = 3'd2,
    EW_GREEN  = 3'd3,
    EW_YELLOW = 3'd4,
    ALL_RED_2 = 3'd5,
    PED_WALK  = 3'd6
`ifdef TLC_NIGHT_FLASH_EN
    , FLASH   = 3'd7
`endif
  } state_t;

  localparam logic [2:0] LIGHT_RED = 3'b100;
  localparam logic [2:0] LIGHT_YEL = 3'b010;
  localparam logic [2:0] LIGHT_GRN = 3'b001;
  localparam logic [2:0] LIGHT_OFF = 3'b000;

  localparam logic NS = 1'b0;
  localparam logic EW = 1'b1;

`ifdef TLC_NIGHT_FLASH_EN
  // Ticks per half-period of the night flash pattern.
  localparam int FLASH_T = 5;
`endif

endpackage

// File: rtl/tlc_phase_timer.sv
// Per-phase down counter: loads D-1 on phase entry, decrements on each tick,
// and flags expiry on the tick that finds it already at zero.
module tlc_phase_timer #(
  parameter int               CNT_W   = 10,
  parameter logic [CNT_W-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             tick,
  output logic [CNT_W-1:0] time_left,
  output logic             expire
);

  assign expire = tick & (time_left == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      time_left <= RST_VAL;
    end else if (load) begin
      time_left <= load_val;
    end else if (tick && time_left != '0) begin
      time_left <= time_left - 1'b1;
    end
  end

endmodule

// File: rtl/tlc_phase_fsm.sv
// Traffic-light phase sequencer with pedestrian walk insertion.
// Define TLC_NIGHT_FLASH_EN to add the night_mode input and FLASH state.
module tlc_phase_fsm
  import tlc_pkg::*;
#(
  parameter int GREEN_T  = 300,
  parameter int YELLOW_T = 40,
  parameter int ALLRED_T = 20,
  parameter int WALK_T   = 100,
  parameter int CNT_W    = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tick,
  input  logic             ped_btn,
`ifdef TLC_NIGHT_FLASH_EN
  input  logic             night_mode,
`endif
  output logic [2:0]       ns_light,
  output logic [2:0]       ew_light,
  output logic             walk,
  output logic             ped_pending,
  output logic [CNT_W-1:0] time_left
);

  state_t           state, state_nxt;
  logic             next_dir, next_dir_nxt;
  logic             ped_pending_nxt;
  logic [2:0]       ns_nxt, ew_nxt;
  logic             walk_nxt;
  logic             load, expire;
  logic [CNT_W-1:0] load_val;
`ifdef TLC_NIGHT_FLASH_EN
  logic             flash_on, flash_nxt;
`endif

  function automatic logic [CNT_W-1:0] phase_len(input state_t s);
    case (s)
      NS_GREEN, EW_GREEN:   phase_len = CNT_W'(GREEN_T - 1);
      NS_YELLOW, EW_YELLOW: phase_len = CNT_W'(YELLOW_T - 1);
      PED_WALK:             phase_len = CNT_W'(WALK_T - 1);
`ifdef TLC_NIGHT_FLASH_EN
      FLASH:                phase_len = CNT_W'(FLASH_T - 1);
`endif
      default:              phase_len = CNT_W'(ALLRED_T - 1);
    endcase
  endfunction

  tlc_phase_timer #(
    .CNT_W   (CNT_W),
    .RST_VAL (CNT_W'(ALLRED_T - 1))
  ) u_timer (
    .clk       (clk),
    .reset     (reset),
    .load      (load),
    .load_val  (load_val),
    .tick      (tick),
    .time_left (time_left),
    .expire    (expire)
  );

  always_comb begin
    state_nxt    = state;
    next_dir_nxt = next_dir;
`ifdef TLC_NIGHT_FLASH_EN
    flash_nxt    = flash_on;
    if (state == FLASH) begin
      if (tick && !night_mode) begin
        state_nxt = ALL_RED_2;
      end else if (expire) begin
        flash_nxt = ~flash_on;
      end
    end else
`endif
    if (expire) begin
      case (state)
        NS_GREEN:  state_nxt = NS_YELLOW;
        NS_YELLOW: state_nxt = ALL_RED_1;
        EW_GREEN:  state_nxt = EW_YELLOW;
        EW_YELLOW: state_nxt = ALL_RED_2;
        ALL_RED_1: begin
          next_dir_nxt = EW;
          state_nxt    = ped_pending ? PED_WALK : EW_GREEN;
        end
        ALL_RED_2: begin
          next_dir_nxt = NS;
          state_nxt    = ped_pending ? PED_WALK : NS_GREEN;
        end
        PED_WALK:  state_nxt = (next_dir == EW) ? EW_GREEN : NS_GREEN;
        default:   state_nxt = ALL_RED_2;
      endcase
`ifdef TLC_NIGHT_FLASH_EN
      // Night mode overrides the normal successor of either clearance phase.
      if ((state == ALL_RED_1 || state == ALL_RED_2) && night_mode) begin
        state_nxt = FLASH;
        flash_nxt = 1'b1;
      end
`endif
    end

    load = (state_nxt != state);
`ifdef TLC_NIGHT_FLASH_EN
    if (state == FLASH && state_nxt == FLASH && expire) load = 1'b1;
`endif
    load_val = phase_len(state_nxt);

    // Entering the walk clears the request even if the button is still held.
    ped_pending_nxt = ped_pending;
    if (state_nxt == PED_WALK && state != PED_WALK) begin
      ped_pending_nxt = 1'b0;
    end else if (ped_btn && state != PED_WALK) begin
      ped_pending_nxt = 1'b1;
    end

    ns_nxt   = LIGHT_RED;
    ew_nxt   = LIGHT_RED;
    walk_nxt = 1'b0;
    case (state_nxt)
      NS_GREEN:  ns_nxt   = LIGHT_GRN;
      NS_YELLOW: ns_nxt   = LIGHT_YEL;
      EW_GREEN:  ew_nxt   = LIGHT_GRN;
      EW_YELLOW: ew_nxt   = LIGHT_YEL;
      PED_WALK:  walk_nxt = 1'b1;
`ifdef TLC_NIGHT_FLASH_EN
      FLASH: begin
        ns_nxt = flash_nxt ? LIGHT_YEL : LIGHT_OFF;
        ew_nxt = flash_nxt ? LIGHT_RED : LIGHT_OFF;
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ALL_RED_2;
      next_dir    <= NS;
      ped_pending <= 1'b0;
      ns_light    <= LIGHT_RED;
      ew_light    <= LIGHT_RED;
      walk        <= 1'b0;
`ifdef TLC_NIGHT_FLASH_EN
      flash_on    <= 1'b0;
`endif
    end else begin
      state       <= state_nxt;
      next_dir    <= next_dir_nxt;
      ped_pending <= ped_pending_nxt;
      ns_light    <= ns_nxt;
      ew_light    <= ew_nxt;
      walk        <= walk_nxt;
`ifdef TLC_NIGHT_FLASH_EN
      flash_on    <= flash_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_tlc_phase_fsm.sv
// Randomized scoreboard bench for tlc_phase_fsm against a phase-table model
// that counts remaining ticks per phase.
module tb_tlc_phase_fsm;

  localparam int GREEN_T  = 5;
  localparam int YELLOW_T = 2;
  localparam int ALLRED_T = 1;
  localparam int WALK_T   = 3;
  localparam int CNT_W    = 10;

  localparam int P_NSG = 0, P_NSY = 1, P_AR1 = 2, P_EWG = 3, P_EWY = 4, P_AR2 = 5, P_WALK = 6;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             tick = 1'b0;
  logic             ped_btn = 1'b0;
  logic [2:0]       ns_light, ew_light;
  logic             walk, ped_pending;
  logic [CNT_W-1:0] time_left;
`ifdef TLC_NIGHT_FLASH_EN
  logic             night_mode = 1'b0;
`endif

  always #5 clk = ~clk;

  tlc_phase_fsm #(
    .GREEN_T  (GREEN_T),
    .YELLOW_T (YELLOW_T),
    .ALLRED_T (ALLRED_T),
    .WALK_T   (WALK_T),
    .CNT_W    (CNT_W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .tick        (tick),
    .ped_btn     (ped_btn),
`ifdef TLC_NIGHT_FLASH_EN
    .night_mode  (night_mode),
`endif
    .ns_light    (ns_light),
    .ew_light    (ew_light),
    .walk        (walk),
    .ped_pending (ped_pending),
    .time_left   (time_left)
  );

  typedef struct {
    int               cyc;
    logic [2:0]       ns;
    logic [2:0]       ew;
    logic             walk;
    logic             pend;
    logic [CNT_W-1:0] tl;
    bit               rst;
  } exp_t;

  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;
  int   tcnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Phase table: duration and head colours per phase.
  int         dur [7] = '{GREEN_T, YELLOW_T, ALLRED_T, GREEN_T, YELLOW_T, ALLRED_T, WALK_T};
  logic [2:0] ns_of [7] = '{3'b001, 3'b010, 3'b100, 3'b100, 3'b100, 3'b100, 3'b100};
  logic [2:0] ew_of [7] = '{3'b100, 3'b100, 3'b100, 3'b001, 3'b010, 3'b100, 3'b100};

  int m_ph   = P_AR2;
  int m_rem  = ALLRED_T;
  bit m_pend = 1'b0;
  bit m_dir_ew = 1'b0;

  function automatic int next_phase(input int ph);
    case (ph)
      P_NSG:  return P_NSY;
      P_NSY:  return P_AR1;
      P_AR1:  begin m_dir_ew = 1'b1; return m_pend ? P_WALK : P_EWG; end
      P_EWG:  return P_EWY;
      P_EWY:  return P_AR2;
      P_AR2:  begin m_dir_ew = 1'b0; return m_pend ? P_WALK : P_NSG; end
      default: return m_dir_ew ? P_EWG : P_NSG;
    endcase
  endfunction

  task automatic step(input bit r, input bit t, input bit b);
    exp_t e;
    int   old;
    @(posedge clk);
    #1;
    reset = r; tick = t; ped_btn = b;
    if (r) begin
      m_ph = P_AR2; m_rem = ALLRED_T; m_pend = 1'b0; m_dir_ew = 1'b0;
    end else begin
      old = m_ph;
      if (t) begin
        if (m_rem > 1) m_rem--;
        else begin
          m_ph  = next_phase(old);
          m_rem = dur[m_ph];
        end
      end
      if (m_ph == P_WALK && old != P_WALK) m_pend = 1'b0;
      else if (b && old != P_WALK) m_pend = 1'b1;
    end
    e.cyc  = cyc + 1;
    e.ns   = ns_of[m_ph];
    e.ew   = ew_of[m_ph];
    e.walk = (m_ph == P_WALK);
    e.pend = m_pend;
    e.tl   = CNT_W'(m_rem - 1);
    e.rst  = r;
    exp_q.push_back(e);
  endtask

  task automatic tstep(input bit b);
    bit t;
    t = (tcnt % 4 == 3);
    tcnt++;
    step(1'b0, t, b);
  endtask

  task automatic bound_check(input bit expired, input string what);
    vectors++;
    if (expired) begin
      miscompares++;
      $display("FAIL bound %s: expired waiting, required reach within budget", what);
    end
  endtask

  // Monitor: compares outputs to the expectation tagged for this edge.
  initial begin
    exp_t       e;
    logic [2:0] prev_ns, prev_ew;
    bit         have_prev;
    have_prev = 1'b0;
    prev_ns = 3'b100;
    prev_ew = 3'b100;
    forever begin
      @(posedge clk);
      #3;
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        e = exp_q.pop_front();
        vectors++; miscompares++;
        $display("FAIL stale expectation cyc=%0d seen at cyc=%0d", e.cyc, cyc);
      end
      if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
        e = exp_q.pop_front();
        vectors++;
        if ({ns_light, ew_light, walk, ped_pending, time_left} !==
            {e.ns, e.ew, e.walk, e.pend, e.tl}) begin
          miscompares++;
          $display("FAIL outputs cyc=%0d got ns=%b ew=%b walk=%b pend=%b tl=%0d, required ns=%b ew=%b walk=%b pend=%b tl=%0d",
                   cyc, ns_light, ew_light, walk, ped_pending, time_left,
                   e.ns, e.ew, e.walk, e.pend, e.tl);
        end
        vectors++;
        if (!($onehot(ns_light) && $onehot(ew_light) &&
              (ns_light == 3'b100 || ew_light == 3'b100))) begin
          miscompares++;
          $display("FAIL heads cyc=%0d got ns=%b ew=%b, required one-hot with at least one red",
                   cyc, ns_light, ew_light);
        end
        if (have_prev && !e.rst) begin
          vectors++;
          if ((prev_ns == 3'b001 && ns_light == 3'b100) ||
              (prev_ew == 3'b001 && ew_light == 3'b100)) begin
            miscompares++;
            $display("FAIL green_to_red cyc=%0d prev ns=%b ew=%b got ns=%b ew=%b, required yellow between",
                     cyc, prev_ns, prev_ew, ns_light, ew_light);
          end
        end
        prev_ns = ns_light;
        prev_ew = ew_light;
        have_prev = 1'b1;
      end
    end
  end

  initial begin
    int g;
    repeat (3) step(1'b1, 1'b0, 1'b0);

    for (int i = 0; i < 200; i++) tstep(1'b0);

    // Single pedestrian pulse during EW green.
    g = 0;
    while (m_ph != P_EWG && g < 200) begin tstep(1'b0); g++; end
    bound_check(g >= 200, "ew_green");
    tstep(1'b1);
    for (int i = 0; i < 120; i++) tstep(1'b0);

    for (int i = 0; i < 600; i++) tstep($urandom_range(0, 39) == 0);

    // Button held across walk entry and beyond.
    for (int i = 0; i < 300; i++) tstep(1'b1);
    for (int i = 0; i < 100; i++) tstep(1'b0);

    // Tick stalled mid EW yellow.
    g = 0;
    while (m_ph != P_EWY && g < 200) begin tstep(1'b0); g++; end
    bound_check(g >= 200, "ew_yellow");
    repeat (100) step(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 80; i++) tstep(1'b0);

    // Reset coinciding with a tick while NS green has time_left = 2.
    g = 0;
    while (!(m_ph == P_NSG && m_rem == 3 && tcnt % 4 == 3) && g < 400) begin
      tstep(1'b0); g++;
    end
    bound_check(g >= 400, "ns_green_tl2");
    tcnt++;
    step(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 100; i++) tstep(1'b0);

    // Random ticks, button bursts and occasional resets.
    begin
      bit b;
      b = 1'b0;
      for (int i = 0; i < 1500; i++) begin
        if ($urandom_range(0, 15) == 0) b = ~b;
        step($urandom_range(0, 299) == 0, $urandom_range(0, 3) == 0, b);
      end
    end

    repeat (3) @(posedge clk);
    #4;
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain got %0d pending expectations, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
